// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiply unit: op encodings, FSM states
// and the operand-magnitude helper used when loading SMULL operands.
package mul_pkg;

    localparam int MUL_ITER = 32;

    localparam logic [1:0] MUL_OP_MUL   = 2'b00;
    localparam logic [1:0] MUL_OP_MLA   = 2'b01;
    localparam logic [1:0] MUL_OP_UMULL = 2'b10;
    localparam logic [1:0] MUL_OP_SMULL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mul_state_t;

    // 0x80000000 maps to itself, which is its correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/mul_fixup.sv
// Final-cycle correction of the raw unsigned product: SMULL sign restore,
// MLA accumulate, MUL/MLA high-word clear and N/Z flag generation.
module mul_fixup
    import mul_pkg::*;
(
    input  logic [1:0]  op,
    input  logic        sign,
    input  logic [63:0] prod,
    input  logic [31:0] acc,
    output logic [31:0] lo,
    output logic [31:0] hi,
    output logic        n_flag,
    output logic        z_flag
);

    logic [63:0] prod_adj_s;

    // Restore the sign of the product and shape the result words for the op.
    always_comb begin
        prod_adj_s = prod;
        lo         = prod[31:0];
        hi         = 32'd0;
        n_flag     = 1'b0;
        z_flag     = 1'b0;
        if ((op == MUL_OP_SMULL) && sign) begin
            prod_adj_s = 64'd0 - prod;
        end else begin
            prod_adj_s = prod;
        end
        case (op)
            MUL_OP_MUL: begin
                lo     = prod_adj_s[31:0];
                hi     = 32'd0;
                n_flag = lo[31];
                z_flag = (lo == 32'd0);
            end
            MUL_OP_MLA: begin
                lo     = prod_adj_s[31:0] + acc;
                hi     = 32'd0;
                n_flag = lo[31];
                z_flag = (lo == 32'd0);
            end
            MUL_OP_UMULL, MUL_OP_SMULL: begin
                lo     = prod_adj_s[31:0];
                hi     = prod_adj_s[63:32];
                n_flag = hi[31];
                z_flag = (prod_adj_s == 64'd0);
            end
            default: begin
                lo     = 32'd0;
                hi     = 32'd0;
                n_flag = 1'b0;
                z_flag = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add multiplier for MUL/MLA/UMULL/SMULL with a fixed
// 34-cycle start-to-done latency and registered results that hold until the next FIX.
module mul_unit
    import mul_pkg::*;
#(
    parameter int ITER = MUL_ITER
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] acc,
    output logic        busy,
    output logic        done,
    output logic [31:0] result_lo,
    output logic [31:0] result_hi,
    output logic        n_flag,
    output logic        z_flag
);

    mul_state_t  state_r;
    mul_state_t  state_nx_s;
    logic [4:0]  cnt_r;
    logic [1:0]  op_r;
    logic [31:0] acc_r;
    logic        sign_r;
    logic [31:0] mcand_r;
    logic [31:0] mplr_r;
    logic [63:0] prod_r;
    logic [32:0] sum_s;
    logic        start_ok_s;
    logic        busy_r;
    logic        done_r;
    logic [31:0] lo_r;
    logic [31:0] hi_r;
    logic        n_r;
    logic        z_r;
    logic [31:0] fix_lo_s;
    logic [31:0] fix_hi_s;
    logic        fix_n_s;
    logic        fix_z_s;

    // Next-state decode; start is only honoured from IDLE or DONE.
    always_comb begin
        state_nx_s = state_r;
        start_ok_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = ST_RUN;
                    start_ok_s = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == 5'(ITER - 1)) begin
                    state_nx_s = ST_FIX;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_FIX: begin
                state_nx_s = ST_DONE;
            end
            ST_DONE: begin
                if (start) begin
                    state_nx_s = ST_RUN;
                    start_ok_s = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // One shift-add step: conditional add into the upper half, carry kept for the shift.
    always_comb begin
        sum_s = {1'b0, prod_r[63:32]};
        if (mplr_r[0]) begin
            sum_s = {1'b0, prod_r[63:32]} + {1'b0, mcand_r};
        end else begin
            sum_s = {1'b0, prod_r[63:32]};
        end
    end

    // State and status register updates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s == ST_RUN) || (state_nx_s == ST_FIX);
            done_r  <= (state_r == ST_FIX);
        end
    end

    // Operand capture on an accepted start, then iterate while in RUN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_r    <= MUL_OP_MUL;
            acc_r   <= 32'd0;
            sign_r  <= 1'b0;
            mcand_r <= 32'd0;
            mplr_r  <= 32'd0;
            prod_r  <= 64'd0;
            cnt_r   <= 5'd0;
        end else if (start_ok_s) begin
            op_r   <= op;
            acc_r  <= acc;
            prod_r <= 64'd0;
            cnt_r  <= 5'd0;
            if (op == MUL_OP_SMULL) begin
                mcand_r <= abs32(a);
                mplr_r  <= abs32(b);
                sign_r  <= a[31] ^ b[31];
            end else begin
                mcand_r <= a;
                mplr_r  <= b;
                sign_r  <= 1'b0;
            end
        end else if (state_r == ST_RUN) begin
            prod_r <= {sum_s, prod_r[31:1]};
            mplr_r <= {1'b0, mplr_r[31:1]};
            cnt_r  <= cnt_r + 5'd1;
        end
    end

    mul_fixup u_fixup (
        .op     (op_r),
        .sign   (sign_r),
        .prod   (prod_r),
        .acc    (acc_r),
        .lo     (fix_lo_s),
        .hi     (fix_hi_s),
        .n_flag (fix_n_s),
        .z_flag (fix_z_s)
    );

    // Result registers load only in FIX so they hold through any following RUN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lo_r <= 32'd0;
            hi_r <= 32'd0;
            n_r  <= 1'b0;
            z_r  <= 1'b0;
        end else if (state_r == ST_FIX) begin
            lo_r <= fix_lo_s;
            hi_r <= fix_hi_s;
            n_r  <= fix_n_s;
            z_r  <= fix_z_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign result_lo = lo_r;
    assign result_hi = hi_r;
    assign n_flag    = n_r;
    assign z_flag    = z_r;

endmodule

// File: doc/mul_unit.md
# mul_unit

Iterative multiply unit for the ARM datapath, directly downstream of the register file: takes the two read ports (Rm, Rs) plus a third operand (Rn/accumulator) and computes MUL, MLA, UMULL or SMULL over multiple cycles. It uses a radix-2 shift-add core and signals completion with a one-cycle `done` pulse. The controller holds the instruction while `busy` is high, then writes `result_lo`/`result_hi` back through the register-file write port.

## Interface
- `ITER`, default 32: number of shift-add iterations; must equal the operand width (fixed at 32).
- `clk`  input  1  the single clock; all state changes on its rising edge.
- `reset_n`  input  1  reset, asynchronous, active-low.
- `start`  input  1  request to begin an operation; sampled only when the unit is in IDLE or DONE.
- `op`  input  2  operation select: MUL=00, MLA=01, UMULL=10, SMULL=11.
- `a`  input  32  multiplicand (Rm, from `rd1`).
- `b`  input  32  multiplier (Rs, from `rd2`).
- `acc`  input  32  accumulator for MLA; ignored for the other ops.
- `busy`  output  1  high in RUN and FIX.
- `done`  output  1  one-cycle pulse; results are valid in this cycle.
- `result_lo`  output  32  low word of the result.
- `result_hi`  output  32  high word of the result; 0 for MUL and MLA.
- `n_flag`, `z_flag`  output  1 each  N and Z of the result. For MUL/MLA they use the 32-bit `result_lo`; for the long ops they use the 64-bit `{hi,lo}`.

## Operation
- States: IDLE, RUN, FIX, DONE.
  - IDLE/DONE with `start`=1 → RUN.
  - RUN with count = ITER-1 → FIX.
  - FIX → DONE.
  - DONE with `start`=0 → IDLE.
- On start:
  - Latch `op` and `acc`.
  - For SMULL, latch |a| and |b| and record sign = a[31]^b[31]. Otherwise latch a and b unchanged.
  - Clear the 64-bit product register and the 5-bit counter.
- RUN, each cycle:
  - If the multiplier LSB is 1, add the 32-bit multiplicand into product[63:32], keeping the carry.
  - Shift product and multiplier right by 1.
  - Increment the counter.
- FIX, single cycle:
  - SMULL with sign=1: negate the 64-bit product (two's complement).
  - MLA: result_lo = product[31:0] + acc mod 2^32.
  - MUL/MLA: result_hi = 0.
  - Register the results and compute the flags.
- The SMULL magnitude of 0x80000000 is 0x80000000, treated as unsigned. No overflow is possible, because the product fits in 64 bits.
- `start` in RUN or FIX is ignored. Operands are not re-sampled.
- `start` in the DONE cycle is accepted (back-to-back operation). `done` still pulses in that cycle, and the next edge enters RUN.
- `result_lo`, `result_hi`, `n_flag` and `z_flag` hold their values from FIX until the next FIX. They do not change during a following RUN.
- Reset (any time, including mid-RUN): state → IDLE, counter → 0, every output → 0. No `done` is produced for an aborted operation.

## Timing
- Reset values: `busy`=0, `done`=0, `result_lo`=0, `result_hi`=0, `n_flag`=0, `z_flag`=0.
- Cycle E: the edge that samples `start` (state in IDLE or DONE).
- E+1 … E+32: RUN iterations. `busy`=1 from just after E.
- E+33: FIX → DONE. `done`=1 and results are valid for exactly the cycle after E+33.
- Start-to-done latency: 34 cycles, fixed and independent of operand values.
- `busy` falls at the same edge at which `done` rises.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `mul_pkg`:
  - op encodings `MUL_OP_MUL/MLA/UMULL/SMULL`.
  - state enum `mul_state_t`.
  - constant `MUL_ITER = 32`.
- One sub-module, `mul_fixup`: combinational FIX logic (conditional negate, accumulate add, flag generation). It is instantiated once. The FSM, counter and shift-add datapath stay in `mul_unit`.

## Test plan
- Reset: assert `reset_n`=0 mid-cycle → all outputs 0 and `busy`=0 immediately (asynchronous); release, idle 5 cycles → `done` never pulses.
- MUL a=7, b=6 → `done` 34 cycles after the start edge; lo=0x0000002A, hi=0, N=0, Z=0. Then a=0, b=5 → lo=0 and Z=1.
- MLA a=0xFFFFFFFF, b=2, acc=3 → lo=0x00000001, hi=0, N=0.
- UMULL a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- SMULL, two cases:
  - a=-3, b=5 → {hi,lo}=0xFFFFFFFF_FFFFFFF1, N=1.
  - a=b=0x80000000 → hi=0x40000000, lo=0, N=0.
- Control:
  - `start` pulsed with new operands at RUN cycle 10 → ignored, and the original result is returned.
  - `reset_n` low at RUN cycle 10 → IDLE, no `done`.
  - `start` held high through the DONE cycle → second result arrives exactly 34 cycles later.
